// File: rtl/coin_sprite_renderer.sv
// ============================================================================
// Module   : coin_sprite_renderer
// Purpose  : Turns the coin animation frame index into per-pixel coin sprite
//            output. Latches the frame index on frame_clk rising edges, holds
//            a writable table of coin positions, hit-tests DrawX/DrawY against
//            it, and drives sprite ROM addresses and palette output.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk          in   pixel clock
//   Reset        in   asynchronous active-high reset
//   frame_clk    in   frame-rate level, synchronous to Clk
//   COINSIGNAL   in   2-bit animation frame index
//   DrawX/DrawY  in   current pixel coordinates
//   coin_we      in   write table entry coin_idx with {coin_x, coin_y}
//   coin_clr     in   mark entry coin_idx collected
//   coin_idx     in   table index for coin_we / coin_clr
//   coin_x/y     in   top-left corner for a write
//   rom_data     in   palette index returned by the sprite ROM
//   rom_addr     out  sprite ROM address (2 cycles after DrawX/DrawY)
//   coin_on      out  opaque coin pixel (3 cycles after DrawX/DrawY)
//   coin_color   out  palette index, 0 when coin_on=0
//   collected    out  saturating count of collected coins
// Optional feature
//   COIN_BOB_EN  when defined, coins bob by one pixel vertically, the bob bit
//                toggling on each frame edge seen while frame_q==3.
// ============================================================================
`default_nettype none

module coin_sprite_renderer #(
  parameter int NUM_COINS = 4,
  parameter int COIN_W    = 16,
  parameter int COIN_H    = 16,
  parameter int ADDR_W    = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [1:0]        COINSIGNAL,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              coin_we,
  input  logic              coin_clr,
  input  logic [2:0]        coin_idx,
  input  logic [9:0]        coin_x,
  input  logic [9:0]        coin_y,
  input  logic [3:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              coin_on,
  output logic [3:0]        coin_color,
  output logic [7:0]        collected
);

  localparam int XW = $clog2(COIN_W);
  localparam int YW = $clog2(COIN_H);

  // --------------------------------------------------------------------------
  // Frame latch: frame index only changes on a frame_clk rising edge so that
  // COINSIGNAL moving mid-frame cannot tear the sprite.
  // --------------------------------------------------------------------------
  logic       frame_prev;
  logic [1:0] frame_q;
  logic       frame_rise;

  assign frame_rise = frame_clk & ~frame_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_prev <= 1'b0;
      frame_q    <= 2'd0;
    end else begin
      frame_prev <= frame_clk;
      if (frame_rise) frame_q <= COINSIGNAL;
    end
  end

`ifdef COIN_BOB_EN
  logic bob;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                            bob <= 1'b0;
    else if (frame_rise && frame_q == 2'd3) bob <= ~bob;
  end
`endif

  // --------------------------------------------------------------------------
  // Coin table
  // --------------------------------------------------------------------------
  logic [9:0]           tab_x [NUM_COINS];
  logic [9:0]           tab_y [NUM_COINS];
  logic [NUM_COINS-1:0] tab_act;
  logic                 idx_ok;
  logic                 clr_hit;
  logic                 clr_count;

  assign idx_ok = (int'(coin_idx) < NUM_COINS);

  always_comb begin
    clr_hit = 1'b0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (coin_idx == 3'(i) && tab_act[i]) clr_hit = 1'b1;
    end
  end

  // There is a single coin_idx, so a simultaneous write and clear always
  // target the same entry; the write wins and nothing is counted.
  assign clr_count = coin_clr && !coin_we && idx_ok && clr_hit;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tab_act   <= '0;
      collected <= 8'd0;
      for (int i = 0; i < NUM_COINS; i++) begin
        tab_x[i] <= 10'd0;
        tab_y[i] <= 10'd0;
      end
    end else begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (idx_ok && coin_idx == 3'(i)) begin
          if (coin_we) begin
            tab_x[i]   <= coin_x;
            tab_y[i]   <= coin_y;
            tab_act[i] <= 1'b1;
          end else if (coin_clr) begin
            tab_act[i] <= 1'b0;
          end
        end
      end
      if (clr_count && collected != 8'hFF) collected <= collected + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // S1: register pixel coordinates
  // --------------------------------------------------------------------------
  logic [9:0] x1;
  logic [9:0] y1;
  logic       v1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x1 <= 10'd0;
      y1 <= 10'd0;
      v1 <= 1'b0;
    end else begin
      x1 <= DrawX;
      y1 <= DrawY;
      v1 <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // S2: per-entry hit test. Bounds use 11 bits so cx+COIN_W-1 never wraps
  // back onto the left edge of the screen.
  // --------------------------------------------------------------------------
  logic [NUM_COINS-1:0] ent_hit;
  logic [XW-1:0]        ent_dx [NUM_COINS];
  logic [YW-1:0]        ent_dy [NUM_COINS];

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_hit
    logic [10:0] cx_e;
    logic [10:0] cy_e;
    logic [10:0] px;
    logic [10:0] py;

`ifdef COIN_BOB_EN
    assign cy_e = {1'b0, tab_y[g]} + {10'd0, bob};
`else
    assign cy_e = {1'b0, tab_y[g]};
`endif
    assign cx_e = {1'b0, tab_x[g]};
    assign px   = {1'b0, x1};
    assign py   = {1'b0, y1};

    assign ent_hit[g] = tab_act[g]
                      && (px >= cx_e) && (px <= cx_e + 11'(COIN_W - 1))
                      && (py >= cy_e) && (py <= cy_e + 11'(COIN_H - 1));

    // Only the low bits of the offset are needed; inside a hit the offset is
    // already below COIN_W / COIN_H, so truncated subtraction is exact.
    assign ent_dx[g] = x1[XW-1:0] - cx_e[XW-1:0];
    assign ent_dy[g] = y1[YW-1:0] - cy_e[YW-1:0];
  end

  logic          hit_n;
  logic [XW-1:0] sel_dx;
  logic [YW-1:0] sel_dy;

  // Scan from the top down so the lowest matching index is the last to land.
  always_comb begin
    hit_n  = 1'b0;
    sel_dx = '0;
    sel_dy = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (ent_hit[i]) begin
        hit_n  = 1'b1;
        sel_dx = ent_dx[i];
        sel_dy = ent_dy[i];
      end
    end
    hit_n = hit_n & v1;
  end

  logic hit2;

  // With power-of-two sprite dimensions the address
  // frame*W*H + dy*W + dx is a plain concatenation.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      hit2     <= 1'b0;
    end else begin
      hit2     <= hit_n;
      rom_addr <= hit_n ? ADDR_W'({frame_q, sel_dy, sel_dx}) : '0;
    end
  end

  // --------------------------------------------------------------------------
  // S3: transparency (palette index 0) and colour output
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      coin_on    <= 1'b0;
      coin_color <= 4'd0;
    end else begin
      coin_on    <= hit2 && (rom_data != 4'd0);
      coin_color <= (hit2 && rom_data != 4'd0) ? rom_data : 4'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_sprite_renderer.sv
// ============================================================================
// Module   : tb_coin_sprite_renderer
// Purpose  : Self-checking bench for coin_sprite_renderer. A behavioural model
//            keeps the coin table, frame index and collected count as plain
//            integers and derives the expected sprite address and colour from
//            screen geometry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_coin_sprite_renderer;

  localparam int NC = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [1:0] COINSIGNAL = 2'd0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic       coin_we = 1'b0;
  logic       coin_clr = 1'b0;
  logic [2:0] coin_idx = 3'd0;
  logic [9:0] coin_x = 10'd0;
  logic [9:0] coin_y = 10'd0;
  logic [3:0] rom_data;
  logic [9:0] rom_addr;
  logic       coin_on;
  logic [3:0] coin_color;
  logic [7:0] collected;

  logic [3:0] rom_mem [1024];

  // Registered rom_addr already accounts for the ROM's read cycle.
  assign rom_data = rom_mem[rom_addr];

  coin_sprite_renderer #(
    .NUM_COINS(NC), .COIN_W(16), .COIN_H(16), .ADDR_W(10)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .COINSIGNAL(COINSIGNAL),
    .DrawX(DrawX), .DrawY(DrawY), .coin_we(coin_we), .coin_clr(coin_clr),
    .coin_idx(coin_idx), .coin_x(coin_x), .coin_y(coin_y),
    .rom_data(rom_data), .rom_addr(rom_addr), .coin_on(coin_on),
    .coin_color(coin_color), .collected(collected)
  );

  always #5 Clk = ~Clk;

  // Reference model state
  int m_x [NC];
  int m_y [NC];
  bit m_act [NC];
  int m_frame;
  int m_coll;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_act[i] = 1'b0;
    end
    m_frame = 0;
    m_coll  = 0;
  endtask

  // Lowest-index active coin whose 16x16 box covers (px,py).
  function automatic bit model_hit(input int px, input int py, output int addr);
    addr = 0;
    for (int i = 0; i < NC; i++) begin
      if (m_act[i] && px >= m_x[i] && px < m_x[i] + 16 &&
          py >= m_y[i] && py < m_y[i] + 16) begin
        addr = m_frame * 256 + (py - m_y[i]) * 16 + (px - m_x[i]);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic op(input bit we, input bit clr, input int idx, input int x, input int y);
    coin_we  = we;
    coin_clr = clr;
    coin_idx = 3'(idx);
    coin_x   = 10'(x);
    coin_y   = 10'(y);
    tick();
    coin_we  = 1'b0;
    coin_clr = 1'b0;
    if (idx < NC) begin
      if (we) begin
        m_x[idx] = x; m_y[idx] = y; m_act[idx] = 1'b1;
      end else if (clr && m_act[idx]) begin
        m_act[idx] = 1'b0;
        if (m_coll < 255) m_coll++;
      end
    end
  endtask

  task automatic frame_pulse(input int sig);
    COINSIGNAL = 2'(sig);
    frame_clk  = 1'b1;
    tick();
    m_frame    = sig;
    frame_clk  = 1'b0;
    tick();
  endtask

  task automatic set_pix(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  // Assumes the pixel has been held for at least 3 cycles.
  task automatic check_pixel(input string tag);
    int  a;
    bit  h;
    bit  on;
    h  = model_hit(int'(DrawX), int'(DrawY), a);
    on = h && (rom_mem[a] != 4'd0);
    chk({tag, "_addr"},  32'(rom_addr), 32'(a));
    chk({tag, "_on"},    32'(coin_on), 32'(on));
    chk({tag, "_color"}, 32'(coin_color), on ? 32'(rom_mem[a]) : 32'd0);
  endtask

  task automatic hold_and_check(input int x, input int y, input string tag);
    set_pix(x, y);
    repeat (3) tick();
    check_pixel(tag);
  endtask

  initial begin
    int px, py, j, r;

    for (int i = 0; i < 1024; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    rom_mem[53] = 4'd7;
    rom_mem[54] = 4'd0;
    model_reset();

    // Reset state
    repeat (3) tick();
    chk("rst_addr",  32'(rom_addr), 32'd0);
    chk("rst_on",    32'(coin_on), 32'd0);
    chk("rst_color", 32'(coin_color), 32'd0);
    chk("rst_coll",  32'(collected), 32'd0);
    Reset = 1'b0;
    tick();

    // COINSIGNAL with frame_clk low must not change the frame
    COINSIGNAL = 2'd2;
    op(1'b1, 1'b0, 0, 100, 50);
    set_pix(0, 0);
    repeat (4) tick();
    set_pix(105, 53);
    tick();
    chk("lat_addr_c1", 32'(rom_addr), 32'd0);
    tick();
    chk("lat_addr_c2", 32'(rom_addr), 32'd53);
    chk("lat_on_c2",   32'(coin_on), 32'd0);
    tick();
    chk("lat_on_c3",    32'(coin_on), 32'd1);
    chk("lat_color_c3", 32'(coin_color), 32'd7);
    hold_and_check(106, 53, "transparent");

    // Frame edge picks up COINSIGNAL=2; later changes while high are ignored
    frame_pulse(2);
    hold_and_check(105, 53, "frame2");
    chk("frame2_base", 32'(rom_addr), 32'd565);
    COINSIGNAL = 2'd0;
    frame_clk  = 1'b1;
    tick();
    m_frame = 0;
    COINSIGNAL = 2'd1;
    repeat (4) tick();
    frame_clk = 1'b0;
    hold_and_check(105, 53, "frame_hold");

    // Collect idx0 twice: counted once
    op(1'b0, 1'b1, 0, 0, 0);
    op(1'b0, 1'b1, 0, 0, 0);
    chk("coll_once", 32'(collected), 32'(m_coll));
    hold_and_check(105, 53, "collected_gone");

    // Overlap: lowest index wins
    op(1'b1, 1'b0, 1, 100, 50);
    op(1'b1, 1'b0, 2, 104, 50);
    hold_and_check(106, 52, "overlap");
    chk("overlap_38", 32'(rom_addr), 32'd38);

    // Same-cycle write and clear: write wins, nothing counted
    op(1'b1, 1'b1, 3, 300, 300);
    chk("we_clr_coll", 32'(collected), 32'(m_coll));
    hold_and_check(301, 301, "we_clr_vis");

    // Right screen edge: no wrap to x=5
    op(1'b1, 1'b0, 3, 1015, 200);
    hold_and_check(1020, 205, "edge_hit");
    hold_and_check(5, 205, "edge_nowrap");
    hold_and_check(1023, 215, "edge_corner");

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)
        op(1'b1, 1'b0, $urandom_range(0, 7), $urandom_range(0, 9) == 0 ?
           $urandom_range(990, 1023) : $urandom_range(0, 120), $urandom_range(0, 120));
      else if (r < 7)
        op(1'b0, 1'b1, $urandom_range(0, 7), 0, 0);
      else if (r < 8)
        op(1'b1, 1'b1, $urandom_range(0, 7), $urandom_range(0, 120), $urandom_range(0, 120));
      else
        frame_pulse($urandom_range(0, 3));
      j  = $urandom_range(0, NC - 1);
      px = m_x[j] + $urandom_range(0, 17) - 1;
      py = m_y[j] + $urandom_range(0, 17) - 1;
      if (px < 0) px = 0;
      if (px > 1023) px = 1023;
      if (py < 0) py = 0;
      if (py > 1023) py = 1023;
      hold_and_check(px, py, "rand");
      chk("rand_coll", 32'(collected), 32'(m_coll));
    end

    // Saturation of the collected counter
    for (int k = 0; k < 300; k++) begin
      op(1'b1, 1'b0, 0, 10, 10);
      op(1'b0, 1'b1, 0, 0, 0);
      if (m_coll == 254) chk("coll_254", 32'(collected), 32'd254);
    end
    chk("coll_sat", 32'(collected), 32'd255);

    // Reset mid-line while a coin pixel is showing
    rom_mem[0] = 4'd9;
    op(1'b1, 1'b0, 0, 400, 400);
    hold_and_check(400, 400, "pre_reset");
    chk("pre_reset_on", 32'(coin_on), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_rst_addr",  32'(rom_addr), 32'd0);
    chk("mid_rst_on",    32'(coin_on), 32'd0);
    chk("mid_rst_color", 32'(coin_color), 32'd0);
    chk("mid_rst_coll",  32'(collected), 32'd0);
    model_reset();
    tick();
    Reset = 1'b0;
    hold_and_check(400, 400, "table_cleared");
    op(1'b1, 1'b0, 0, 400, 400);
    hold_and_check(400, 400, "resume");
    chk("resume_on", 32'(coin_on), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
